gigatron_ram_loader: RTL and testbench



---
 rtl/gigatron_ram_loader_if.sv | 23 ++
 rtl/gigatron_ram_loader.sv | 182 ++++++++++++++++++
 tb/tb_gigatron_ram_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gigatron_ram_loader_if.sv
// Byte-stream and RAM-port bundle between an upstream byte source and gigatron_ram_loader.
// The loader takes the slave modport; the byte source or testbench takes the master modport.
interface gigatron_ram_loader_if;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_byte;
    logic [15:0] o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    modport master (
        output i_valid, i_byte,
        input  o_ready, o_ram_addr, o_ram_we, o_ram_data, o_busy, o_done, o_error
    );

    modport slave (
        input  i_valid, i_byte,
        output o_ready, o_ram_addr, o_ram_we, o_ram_data, o_busy, o_done, o_error
    );
endinterface

// File: rtl/gigatron_ram_loader.sv
// Framed byte-stream loader that writes program bytes into gigatron_ram while o_busy is high.
// Define GIGATRON_LOADER_TIMEOUT_EN to abort a stalled frame after TIMEOUT_CYCLES idle cycles.
module gigatron_ram_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                  i_clock,
    input logic                  i_reset_n,
    gigatron_ram_loader_if.slave bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_ADDR_LO = 3'd2;
    localparam logic [2:0] S_LEN     = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] addr_q;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        accept;
    logic [7:0]  sum_next;

`ifdef GIGATRON_LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        waiting;
`endif

    assign accept   = bus.i_valid & ready_q;
    assign sum_next = csum_q + bus.i_byte;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        data_d  = data_q;
        ready_d = 1'b1;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (bus.i_byte == SYNC_BYTE)) begin
                    csum_d  = bus.i_byte;
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (accept) begin
                    ptr_d[15:8] = bus.i_byte;
                    csum_d      = sum_next;
                    busy_d      = 1'b1;
                    state_d     = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (accept) begin
                    ptr_d[7:0] = bus.i_byte;
                    csum_d     = sum_next;
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    rem_d   = (bus.i_byte == 8'd0) ? 9'd256 : {1'b0, bus.i_byte};
                    csum_d  = sum_next;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_d  = bus.i_byte;
                    we_d    = 1'b1;
                    ready_d = 1'b0;
                    csum_d  = sum_next;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // RAM commits here using the address it registered on the accept edge.
                ptr_d   = ptr_q + 16'd1;
                rem_d   = rem_q - 9'd1;
                state_d = (rem_q == 9'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    done_d  = (sum_next == 8'd0);
                    err_d   = (sum_next != 8'd0);
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

`ifdef GIGATRON_LOADER_TIMEOUT_EN
        waiting = (state_q != S_IDLE) && (state_q != S_WRITE);
        tmo_d   = tmo_q;
        if (accept) begin
            tmo_d = '0;
        end else if (waiting) begin
            tmo_d = tmo_q + 32'd1;
        end
        if (!accept && waiting && (tmo_q == TMO_LAST)) begin
            err_d   = 1'b1;
            done_d  = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            // Address tracks the next pointer so it is stable one edge before each write.
            addr_q  <= ptr_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef GIGATRON_LOADER_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign bus.o_ready    = ready_q;
    assign bus.o_ram_addr = addr_q;
    assign bus.o_ram_we   = we_q;
    assign bus.o_ram_data = data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_error    = err_q;

endmodule

// File: tb/tb_gigatron_ram_loader.sv
// Randomized bench for gigatron_ram_loader: frames are checked against an address->byte
// reference memory built from the frame rules, with a registered-address RAM model on the bus.
module tb_gigatron_ram_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gigatron_ram_loader_if bus ();

    gigatron_ram_loader #(
        .SYNC_BYTE     (8'h55),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model: address registered every edge, write lands at the previously registered address.
    logic [7:0]  ram     [65536];
    logic [7:0]  exp_ram [65536];
    logic [15:0] ram_addr_reg = '0;
    int we_cnt = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0, busy_cycles = 0;

    always @(negedge clk) begin
        if (bus.o_ram_we) begin
            ram[ram_addr_reg] = bus.o_ram_data;
            we_cnt++;
            if (!bus.o_busy) viol_cnt++;
        end
        ram_addr_reg = bus.o_ram_addr;
        if (bus.o_busy) busy_cycles++;
        if (bus.o_done) begin
            done_cnt++;
            if (bus.o_busy) viol_cnt++;
        end
        if (bus.o_error) begin
            err_cnt++;
            if (bus.o_busy) viol_cnt++;
        end
        if (bus.o_done && bus.o_error) viol_cnt++;
    end

    logic [7:0] pl[$];

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  tries = 0;
        bit  acc   = 1'b0;
        while (!acc) begin
            @(negedge clk);
            bus.i_byte  = b;
            bus.i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.i_valid && bus.o_ready) begin
                acc = 1'b1;
                @(posedge clk);
            end else begin
                tries++;
                if (tries > 200) begin
                    check("accept_bound", 32'(bus.o_ready), 32'd1);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [7:0] frame_sum(input logic [15:0] addr);
        logic [7:0] s;
        s = 8'h55 + addr[15:8] + addr[7:0] + 8'(pl.size());
        foreach (pl[i]) s = s + pl[i];
        return s;
    endfunction

    task automatic expect_writes(input logic [15:0] addr);
        foreach (pl[i]) exp_ram[addr + 16'(i)] = pl[i];
    endtask

    task automatic check_mem(input string tag, input logic [15:0] addr);
        for (int i = -1; i <= pl.size(); i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            check({tag, "_mem"}, 32'(ram[a]), 32'(exp_ram[a]));
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] addr, input bit good,
                             input bit rnd, input int noise);
        int w0, d0, e0, v0, b0;
        logic [7:0] cs, nb;
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt; v0 = viol_cnt; b0 = busy_cycles;
        cs = 8'h00 - frame_sum(addr);
        if (!good) cs = cs + 8'($urandom_range(1, 255));
        expect_writes(addr);
        for (int i = 0; i < noise; i++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == 8'h55) nb = 8'h54;
            send_byte(nb, rnd);
        end
        send_byte(8'h55, rnd);
        send_byte(addr[15:8], rnd);
        send_byte(addr[7:0], rnd);
        send_byte(8'(pl.size()), rnd);
        foreach (pl[i]) send_byte(pl[i], rnd);
        send_byte(cs, rnd);
        go_idle();
        repeat (3) @(negedge clk);
        check({tag, "_we"},   32'(we_cnt - w0),   32'(pl.size()));
        check({tag, "_done"}, 32'(done_cnt - d0), good ? 32'd1 : 32'd0);
        check({tag, "_err"},  32'(err_cnt - e0),  good ? 32'd0 : 32'd1);
        check({tag, "_viol"}, 32'(viol_cnt - v0), 32'd0);
        check({tag, "_busyseen"}, 32'(busy_cycles > b0), 32'd1);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check_mem(tag, addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.o_ready),    32'd0);
        check({tag, "_addr"},  32'(bus.o_ram_addr), 32'd0);
        check({tag, "_we"},    32'(bus.o_ram_we),   32'd0);
        check({tag, "_data"},  32'(bus.o_ram_data), 32'd0);
        check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
        check({tag, "_done"},  32'(bus.o_done),     32'd0);
        check({tag, "_err"},   32'(bus.o_error),    32'd0);
    endtask

    initial begin
        int w0, e0, d0, n;
        logic [15:0] a;
        bus.i_valid = 1'b0;
        bus.i_byte  = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'h00;
            exp_ram[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_after", 32'(bus.o_ready), 32'd1);

        // Directed frames; checksums come from the zero-sum rule.
        pl = '{8'hAA, 8'hBB};
        run_frame("basic", 16'h1234, 1'b1, 1'b0, 0);
        pl = '{8'hAA, 8'hBB};
        run_frame("badcs", 16'h1234, 1'b0, 1'b0, 0);
        pl = '{8'h5A, 8'hC3};
        run_frame("noise", 16'h0400, 1'b1, 1'b0, 3);
        pl = '{8'h11, 8'h22};
        run_frame("wrap", 16'hFFFF, 1'b1, 1'b0, 0);

        pl = {};
        for (int i = 0; i < 256; i++) pl.push_back(8'($urandom_range(0, 255)));
        run_frame("len256", 16'h8000, 1'b1, 1'b0, 0);
        run_frame("len256_rnd", 16'h8000, 1'b1, 1'b1, 0);

        for (int f = 0; f < 6; f++) begin
            int len;
            len = (f == 0) ? 256 : int'($urandom_range(1, 40));
            pl = {};
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            a = (f == 1) ? 16'hFFF8 : 16'($urandom_range(0, 65535));
            run_frame("rand", a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
        end

        // Reset while the first of two payload bytes is being written.
        pl = '{8'hAA, 8'hBB};
        send_byte(8'h55, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        w0 = we_cnt;
        #1 rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_nowe", 32'(we_cnt - w0), 32'd0);
        check("midrst_mem", 32'(ram[16'h2000]), 32'(exp_ram[16'h2000]));

        // Stall after LEN.
        pl = '{8'hAA, 8'hBB};
        e0 = err_cnt; d0 = done_cnt;
        send_byte(8'h55, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
`ifdef GIGATRON_LOADER_TIMEOUT_EN
        n = 0;
        while (!bus.o_error && n < 100) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            n++;
        end
        check("tmo_latency", 32'(n - 1), 32'd16);
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        check("tmo_busy", 32'(bus.o_busy), 32'd0);
        pl = '{8'h01, 8'h02, 8'h03};
        run_frame("after_tmo", 16'h3100, 1'b1, 1'b0, 0);
`else
        n = 0;
        repeat (60) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            n++;
        end
        check("stall_err", 32'(err_cnt - e0), 32'd0);
        check("stall_busy", 32'(bus.o_busy), 32'd1);
        expect_writes(16'h3000);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h00 - frame_sum(16'h3000), 1'b0);
        go_idle();
        repeat (3) @(negedge clk);
        check("stall_done", 32'(done_cnt - d0), 32'd1);
        check_mem("stall", 16'h3000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
